// File: rtl/mprj_wb_pkg.sv
// Shared types and constants for the management-core to user-project Wishbone bridge.
package mprj_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          TO_CNT_W         = 8;

endpackage

// File: rtl/mprj_wb_bridge_if.sv
// Core-side and user-side Wishbone signals of the bridge; slave is the bridge view.
interface mprj_wb_bridge_if;

  logic        mprj_cyc_o;
  logic        mprj_stb_o;
  logic        mprj_we_o;
  logic [3:0]  mprj_sel_o;
  logic [31:0] mprj_adr_o;
  logic [31:0] mprj_dat_o;
  logic        mprj_wb_iena;
  logic        mprj_ack_i;
  logic [31:0] mprj_dat_i;

  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic        wbs_we_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_i;
  logic [31:0] wbs_dat_i;

  modport slave (
    input  mprj_cyc_o, mprj_stb_o, mprj_we_o, mprj_sel_o, mprj_adr_o, mprj_dat_o,
           mprj_wb_iena, wbs_ack_i, wbs_dat_i,
    output mprj_ack_i, mprj_dat_i,
           wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
  );

  modport master (
    output mprj_cyc_o, mprj_stb_o, mprj_we_o, mprj_sel_o, mprj_adr_o, mprj_dat_o,
           mprj_wb_iena, wbs_ack_i, wbs_dat_i,
    input  mprj_ack_i, mprj_dat_i,
           wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
  );

endinterface

// File: rtl/mprj_wb_timer.sv
// Per-request cycle counter; expired marks the last cycle a request may stay outstanding.
module mprj_wb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int         W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mprj_wb_bridge.sv
// Bridges one core Wishbone request to the user project, forcing an error
// completion when the user side does not ack within TIMEOUT_CYCLES.
module mprj_wb_bridge
  import mprj_wb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                core_clk,
  input  logic                core_rstn,
  mprj_wb_bridge_if.slave     bus,
  output logic                to_pulse,
  output logic [TO_CNT_W-1:0] to_count
);

  wb_state_e   state;
  logic        stb_q, we_q, ack_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, wdat_q, rdat_q;
  logic        req_start, expired;

  assign req_start = (state == IDLE) && bus.mprj_cyc_o && bus.mprj_stb_o;

  mprj_wb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (core_clk),
    .rst_n   (core_rstn),
    .clear   (req_start),
    .enable  (state == REQ),
    .expired (expired)
  );

  // Abort outranks ack, and ack outranks the timeout on the final timer cycle.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state    <= IDLE;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      adr_q    <= 32'h0;
      wdat_q   <= 32'h0;
      rdat_q   <= 32'h0;
      ack_q    <= 1'b0;
      to_pulse <= 1'b0;
      to_count <= '0;
    end else begin
      to_pulse <= 1'b0;
      case (state)
        IDLE: if (req_start) begin
          we_q   <= bus.mprj_we_o;
          sel_q  <= bus.mprj_sel_o;
          adr_q  <= bus.mprj_adr_o;
          wdat_q <= bus.mprj_dat_o;
          stb_q  <= 1'b1;
          state  <= REQ;
        end
        REQ: if (!bus.mprj_cyc_o) begin
          stb_q <= 1'b0;
          state <= IDLE;
        end else if (bus.wbs_ack_i) begin
          rdat_q <= bus.mprj_wb_iena ? bus.wbs_dat_i : 32'h0;
          stb_q  <= 1'b0;
          ack_q  <= 1'b1;
          state  <= RESP;
        end else if (expired) begin
          rdat_q   <= ERR_DATA;
          to_pulse <= 1'b1;
          if (to_count != {TO_CNT_W{1'b1}}) to_count <= to_count + 1'b1;
          stb_q    <= 1'b0;
          ack_q    <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          stb_q <= 1'b0;
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wbs_cyc_o  = stb_q;
  assign bus.wbs_stb_o  = stb_q;
  assign bus.wbs_we_o   = we_q;
  assign bus.wbs_sel_o  = sel_q;
  assign bus.wbs_adr_o  = adr_q;
  assign bus.wbs_dat_o  = wdat_q;
  assign bus.mprj_ack_i = ack_q;
  assign bus.mprj_dat_i = rdat_q;

endmodule
